// File: rtl/mul_div_engine.sv
// mul_div_engine: single-outstanding signed/unsigned multiply and radix-4 divide.
// Latency: MUL = MUL_LAT cycles, DIV = WIDTH/2+1 cycles (1 on a fast path), NOP = 1 cycle.
// Backpressure: the result is held in DONE until out_ready; in_ready is high only in IDLE.
//
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset
//   in_src0 / in_src1     multiplicand / multiplier, or dividend / divisor
//   in_op, in_sign, in_id operation (01 MUL, 10 DIV, else NOP), signed mode, tag
//   in_valid / in_ready   request handshake; in_flush discards any in-flight or held result
//   out_valid / out_ready result handshake
//   out_res0 / out_res1   MUL: product low/high half; DIV: quotient/remainder
//   out_id, out_dbz       returned tag, divide-by-zero flag
module mul_div_engine #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 2,
  parameter int ID_W    = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_src0,
  input  logic [WIDTH-1:0] in_src1,
  input  logic [1:0]       in_op,
  input  logic             in_sign,
  input  logic [ID_W-1:0]  in_id,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res0,
  output logic [WIDTH-1:0] out_res1,
  output logic [ID_W-1:0]  out_id,
  output logic             out_dbz
);

  // Partial remainder width: rem < d < 2^WIDTH, so (rem << 2) + 3 < 2^(WIDTH+2).
  localparam int RW      = WIDTH + 3;
  localparam int HALF    = WIDTH / 2;
  localparam int CNT_MAX = (HALF > MUL_LAT) ? HALF : MUL_LAT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [1:0]       OP_MUL  = 2'b01;
  localparam logic [1:0]       OP_DIV  = 2'b10;
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0] cnt;
  logic [RW-1:0]    rem_q;    // divide partial remainder
  logic [WIDTH-1:0] dq_q;     // DIV: dividend bits shift out, quotient digits shift in; MUL: multiplicand
  logic [WIDTH-1:0] d_q;      // DIV: |divisor|; MUL: multiplier
  logic             sign_q;
  logic             a_neg_q;  // remainder takes the dividend's sign
  logic             q_neg_q;  // quotient negative iff operand signs differ
  logic [WIDTH-1:0] res0, res1;
  logic [ID_W-1:0]  id_q;
  logic             dbz_q;

  logic accept;
  assign accept = in_valid && in_ready && !in_flush;

  // ---------------------------------------------------------------
  // Operand preparation for the divider (evaluated on the accept cycle)
  // ---------------------------------------------------------------
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_abs, b_abs;
  logic             div_zero, div_ovf, div_small;

  assign a_neg = in_sign & in_src0[WIDTH-1];
  assign b_neg = in_sign & in_src1[WIDTH-1];
  assign a_abs = a_neg ? (-in_src0) : in_src0;
  assign b_abs = b_neg ? (-in_src1) : in_src1;

  assign div_zero  = (in_src1 == '0);
  assign div_ovf   = in_sign && (in_src0 == MIN_NEG) && (in_src1 == '1);
  assign div_small = (a_abs < b_abs);

  // One radix-4 restoring step: bring down two dividend bits, then subtract the
  // largest of 3d, 2d, d that fits. Returns {new remainder, shifted dq}.
  function automatic logic [RW+WIDTH-1:0] div_step(
    input logic [RW-1:0]    rem,
    input logic [WIDTH-1:0] dq,
    input logic [WIDTH-1:0] d
  );
    logic [RW-1:0] base, d1, d2, d3, rem_n;
    logic [1:0]    digit;
    base = (rem << 2) | {{(RW-2){1'b0}}, dq[WIDTH-1 -: 2]};
    d1   = {3'b000, d};
    d2   = {2'b00, d, 1'b0};
    d3   = d1 + d2;
    if (base >= d3) begin
      digit = 2'd3;
      rem_n = base - d3;
    end else if (base >= d2) begin
      digit = 2'd2;
      rem_n = base - d2;
    end else if (base >= d1) begin
      digit = 2'd1;
      rem_n = base - d1;
    end else begin
      digit = 2'd0;
      rem_n = base;
    end
    return {rem_n, dq[WIDTH-3:0], digit};
  endfunction

  // The first digit is retired on the accept edge, leaving WIDTH/2-1 steps in
  // DIV so that iterations plus FIX take WIDTH/2+1 cycles in total.
  logic [RW+WIDTH-1:0] step0;
  logic [RW+WIDTH-1:0] step_n;
  assign step0  = div_step({RW{1'b0}}, a_abs, b_abs);
  assign step_n = div_step(rem_q, dq_q, d_q);

  // ---------------------------------------------------------------
  // Multiplier: operands held in dq_q/d_q while the FSM counts MUL_LAT.
  // With MUL_LAT == 1 the product is taken straight from the inputs.
  // ---------------------------------------------------------------
  logic [WIDTH-1:0]   mul_a, mul_b;
  logic               mul_s;
  logic [2*WIDTH-1:0] mul_a_ext, mul_b_ext, product;

  assign mul_a     = (MUL_LAT == 1) ? in_src0 : dq_q;
  assign mul_b     = (MUL_LAT == 1) ? in_src1 : d_q;
  assign mul_s     = (MUL_LAT == 1) ? in_sign : sign_q;
  assign mul_a_ext = {{WIDTH{mul_s & mul_a[WIDTH-1]}}, mul_a};
  assign mul_b_ext = {{WIDTH{mul_s & mul_b[WIDTH-1]}}, mul_b};
  // Low 2*WIDTH bits of the extended product are correct for both signednesses.
  assign product   = mul_a_ext * mul_b_ext;

  // ---------------------------------------------------------------
  // FSM next state
  // ---------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (in_op == OP_MUL) begin
            state_nxt = (MUL_LAT == 1) ? DONE : MUL;
          end else if (in_op == OP_DIV) begin
            state_nxt = (div_zero || div_ovf || div_small) ? DONE : DIV;
          end else begin
            state_nxt = DONE;
          end
        end
      end
      MUL:     if (cnt == CNT_W'(1)) state_nxt = DONE;
      DIV:     if (cnt == CNT_W'(1)) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // Flush wins over everything, including a same-cycle result handshake.
    if (in_flush) state_nxt = IDLE;
  end

  // ---------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      rem_q   <= '0;
      dq_q    <= '0;
      d_q     <= '0;
      sign_q  <= 1'b0;
      a_neg_q <= 1'b0;
      q_neg_q <= 1'b0;
      res0    <= '0;
      res1    <= '0;
      id_q    <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state <= state_nxt;

      if (accept) begin
        id_q    <= in_id;
        sign_q  <= in_sign;
        a_neg_q <= a_neg;
        q_neg_q <= a_neg ^ b_neg;
        dbz_q   <= 1'b0;
        if (in_op == OP_MUL) begin
          dq_q <= in_src0;
          d_q  <= in_src1;
          cnt  <= CNT_W'(MUL_LAT - 1);
          if (MUL_LAT == 1) {res1, res0} <= product;
        end else if (in_op == OP_DIV) begin
          if (div_zero) begin
            res0  <= '1;
            res1  <= in_src0;
            dbz_q <= 1'b1;
          end else if (div_ovf) begin
            res0 <= MIN_NEG;
            res1 <= '0;
          end else if (div_small) begin
            res0 <= '0;
            res1 <= in_src0;
          end else begin
            {rem_q, dq_q} <= step0;
            d_q           <= b_abs;
            cnt           <= CNT_W'(HALF - 1);
          end
        end else begin
          res0 <= '0;
          res1 <= '0;
        end
      end

      case (state)
        MUL: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) {res1, res0} <= product;
        end
        DIV: begin
          {rem_q, dq_q} <= step_n;
          cnt           <= cnt - CNT_W'(1);
        end
        FIX: begin
          res0 <= q_neg_q ? (-dq_q) : dq_q;
          res1 <= a_neg_q ? (-rem_q[WIDTH-1:0]) : rem_q[WIDTH-1:0];
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign out_res0  = res0;
  assign out_res1  = res1;
  assign out_id    = id_q;
  assign out_dbz   = dbz_q;

endmodule
